onewire_slave: RTL
==================

Name: onewire_slave

Overview:
- 1-Wire responder (slave). It is the far end of the 1-Wire master controller and connects to the `onewire_slv` side of the shared open-drain bus in `top`.
- Detects master reset pulses and answers each one with a presence pulse.
- Decodes master write slots into bytes, LSB first.
- Drives read slots from a byte supplied by fabric logic. This lets the board run master-to-slave loopback without an external device.

Parameters:
- CLK_HZ, 10_000_000, system clock frequency; all timing derives from TICKS_US = CLK_HZ/1_000_000.
- RST_DET_US, 400, minimum continuous low time (µs) recognised as a bus reset.
- PRES_WAIT_US, 30, delay from the bus rising after reset to the start of the presence pulse.
- PRES_US, 120, presence pulse width.
- SAMPLE_US, 30, delay from a slot's falling edge to sampling a write bit.
- RD_HOLD_US, 30, time the slave holds the bus low when transmitting a 0.

Ports:
- clk_10, input, 1, system clock.
- arst_n, input, 1, asynchronous active-low reset.
- ow_i, input, 1, raw bus level (asynchronous).
- ow_oe, output, 1, 1 = pull bus low; 0 = release (pullup or IO buffer outside).
- rx_dat, output, 8, last received byte.
- rx_vld, output, 1, one-cycle pulse; rx_dat is valid in the same cycle.
- tx_dat, input, 8, byte to send in the next 8 read slots.
- tx_vld, input, 1, fabric offers tx_dat.
- tx_rdy, output, 1, one-cycle pulse; tx_dat is accepted in that cycle.
- bus_rst, output, 1, one-cycle pulse when a bus reset is detected.
- busy, output, 1, high from reset detection until the presence pulse ends, and during any partially transferred byte.

Behaviour:
- Clock, reset and synchronisation:
  - Single clock domain `clk_10`. `arst_n` is asynchronous and active-low.
  - While `arst_n` is low, all outputs are held at 0 (ow_oe = 0, rx_dat = 0) and the FSM is in IDLE.
  - `ow_i` passes through a 2-FF synchroniser; all timing is measured on the synchronised level (2-cycle latency).
  - Falling/rising edge flags are derived from the synchronised signal and its previous value.
- Low-time counter:
  - `low_cnt` counts cycles while the synchronised bus is low and saturates at RST_DET_US*TICKS_US.
  - It clears when the bus is high.
  - Reaching the threshold takes priority over every FSM state: the FSM aborts and enters RST_LOW.
  - Any partially assembled rx byte or tx byte is discarded; no rx_vld is issued and no additional tx_rdy is issued.
  - ow_oe is released immediately.
  - bus_rst pulses once per reset, on the cycle the threshold is reached.
- FSM states (onewire_pkg::ow_state_t):
  - IDLE: bus ignored except for reset detection.
  - RST_LOW: wait for the bus to go high, then go to PRES_WAIT.
  - PRES_WAIT: count PRES_WAIT_US, then go to PRES_DRIVE.
  - PRES_DRIVE: ow_oe = 1 for PRES_US. Then release, set bit_cnt = 0, go to BYTE_START.
  - BYTE_START: if tx_vld = 1, latch tx_dat into the shift register, pulse tx_rdy, set mode = TX. Otherwise mode = RX. Go to SLOT_WAIT in the same cycle.
  - SLOT_WAIT: wait for a falling edge, then start the slot counter.
    - In RX mode go to RX_SAMPLE.
    - In TX mode with a current bit of 0: go to TX_HOLD and set ow_oe = 1 from the cycle after the edge.
    - In TX mode with a current bit of 1: go to SLOT_END.
  - RX_SAMPLE: at SAMPLE_US*TICKS_US cycles after the edge, shift the bus level into bit 7 of the shift register (shift right), then go to SLOT_END.
  - TX_HOLD: after RD_HOLD_US*TICKS_US cycles, release ow_oe and go to SLOT_END.
  - SLOT_END: wait for the bus to be high.
    - Then increment bit_cnt.
    - When bit_cnt wraps from 7 to 0: if in RX mode, set rx_dat = shift register and pulse rx_vld. Go to BYTE_START.
    - Otherwise go to SLOT_WAIT.
- Falling edges that occur while ow_oe = 1 or outside SLOT_WAIT are ignored.
- tx_vld is sampled only in BYTE_START. A tx_vld that rises mid-byte takes effect at the next byte boundary.
- After a reset, the FSM stays in the byte loop indefinitely until the next bus reset.
- Counters: one 13-bit slot/phase counter (shared, cleared on each state entry), one 13-bit low counter, one 3-bit bit counter. Widths are derived with $clog2 from the largest threshold.

Decomposition:
- onewire_pkg holds:
  - the ow_state_t enum;
  - the ow_mode_t enum (RX/TX);
  - the timing defaults;
  - the helper function us2cyc(us, clk_hz).
- One sub-module, onewire_sync: 2-FF synchroniser plus registered fall/rise edge flags. It is reusable by the master.

Test Plan:
- Master low 480µs, then release → bus_rst pulse ~400µs (+2 cycles) after the fall. ow_oe rises 30µs after the bus rises and lasts exactly 1200 cycles. busy is low afterwards.
- Reset, then master write slots for 0xCC (LSB first; 0 = 60µs low, 1 = 6µs low; 70µs slots) → single rx_vld with rx_dat = 0xCC after the 8th slot's bus-high.
- Reset, then tx_vld = 1 with tx_dat = 0xA5, then 8 read slots (master 2µs low, sample at 13µs) → tx_rdy pulses once. Sampled bits are 1,0,1,0,0,1,0,1. ow_oe is high for 300 cycles only in the 0 slots. No rx_vld.
- Low pulse of 300µs → no bus_rst, no presence. A subsequent full reset still works.
- After reset, 3 write slots, then a 480µs low → no rx_vld, bus_rst pulse, presence pulse. A following byte 0x3C is received intact.
- Assert arst_n low during PRES_DRIVE → ow_oe = 0 asynchronously. After release, the FSM is IDLE and ignores slots until the next bus reset.

Source files
------------

// File: rtl/onewire_pkg.sv
// Shared types, timing defaults and helpers for the 1-Wire blocks.
// Cycle thresholds are derived from microsecond values and the system clock.
package onewire_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RST_LOW,
    PRES_WAIT,
    PRES_DRIVE,
    BYTE_START,
    SLOT_WAIT,
    RX_SAMPLE,
    TX_HOLD,
    SLOT_END
  } ow_state_t;

  typedef enum logic {
    MODE_RX,
    MODE_TX
  } ow_mode_t;

  localparam int OW_CLK_HZ       = 10_000_000;
  localparam int OW_RST_DET_US   = 400;
  localparam int OW_PRES_WAIT_US = 30;
  localparam int OW_PRES_US      = 120;
  localparam int OW_SAMPLE_US    = 30;
  localparam int OW_RD_HOLD_US   = 30;

  function automatic int us2cyc(input int us, input int clk_hz);
    return us * (clk_hz / 1_000_000);
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/onewire_sync.sv
// Two-flop synchroniser for the raw bus level with registered edge flags.
// Edge flags are asserted in the same cycle the synchronised level changes.
module onewire_sync (
  input  logic clk,
  input  logic arst_n,
  input  logic d_i,
  output logic lvl_o,
  output logic fall_o,
  output logic rise_o
);

  logic meta_q, sync_q, fall_q, rise_q;
  logic fall_d, rise_d;

  // sync_q takes meta_q next cycle, so compare them to flag the upcoming edge
  always_comb begin
    fall_d = sync_q & ~meta_q;
    rise_d = ~sync_q & meta_q;
  end

  // Idle bus is high; resetting the chain high avoids a spurious fall
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      fall_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      fall_q <= fall_d;
      rise_q <= rise_d;
    end
  end

  assign lvl_o  = sync_q;
  assign fall_o = fall_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/onewire_slave.sv
// 1-Wire responder: answers bus resets with presence, decodes write slots
// into bytes (LSB first) and drives read slots from a fabric-supplied byte.
module onewire_slave
  import onewire_pkg::*;
#(
  parameter int CLK_HZ       = OW_CLK_HZ,
  parameter int RST_DET_US   = OW_RST_DET_US,
  parameter int PRES_WAIT_US = OW_PRES_WAIT_US,
  parameter int PRES_US      = OW_PRES_US,
  parameter int SAMPLE_US    = OW_SAMPLE_US,
  parameter int RD_HOLD_US   = OW_RD_HOLD_US
) (
  input  logic       clk_10,
  input  logic       arst_n,
  input  logic       ow_i,
  output logic       ow_oe,
  output logic [7:0] rx_dat,
  output logic       rx_vld,
  input  logic [7:0] tx_dat,
  input  logic       tx_vld,
  output logic       tx_rdy,
  output logic       bus_rst,
  output logic       busy
);

  localparam int RST_CYC  = us2cyc(RST_DET_US, CLK_HZ);
  localparam int PWT_CYC  = us2cyc(PRES_WAIT_US, CLK_HZ);
  localparam int PRES_CYC = us2cyc(PRES_US, CLK_HZ);
  localparam int SMP_CYC  = us2cyc(SAMPLE_US, CLK_HZ);
  localparam int HOLD_CYC = us2cyc(RD_HOLD_US, CLK_HZ);
  localparam int MAX_CYC  = imax(imax(RST_CYC, PRES_CYC),
                                 imax(PWT_CYC, imax(SMP_CYC, HOLD_CYC)));
  localparam int CW       = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] LOW_TH   = CW'(RST_CYC);
  localparam logic [CW-1:0] LOW_M1   = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] PWT_M1   = CW'(PWT_CYC - 1);
  localparam logic [CW-1:0] PRES_M1  = CW'(PRES_CYC - 1);
  localparam logic [CW-1:0] SMP_M1   = CW'(SMP_CYC - 1);
  localparam logic [CW-1:0] HOLD_M1  = CW'(HOLD_CYC - 1);

  logic lvl, fall, rise;

  onewire_sync u_sync (
    .clk    (clk_10),
    .arst_n (arst_n),
    .d_i    (ow_i),
    .lvl_o  (lvl),
    .fall_o (fall),
    .rise_o (rise)
  );

  ow_state_t     state_q, state_d;
  ow_mode_t      mode_q, mode_d;
  logic [7:0]    sh_q, sh_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] low_cnt_q, low_cnt_d;
  logic [7:0]    rx_dat_q, rx_dat_d;
  logic          rx_vld_q, rx_vld_d;
  logic          bus_rst_q, bus_rst_d;
  logic          ow_oe_q, ow_oe_d;
  logic          busy_q, busy_d;
  logic          rst_hit;

  // Fires only on the transition into saturation, so once per reset
  assign rst_hit = ~lvl && (low_cnt_q == LOW_M1);

  // ---------------- state register ----------------
  always_ff @(posedge clk_10 or negedge arst_n) begin
    if (!arst_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    if (rst_hit) begin
      state_d = RST_LOW;
    end else begin
      unique case (state_q)
        IDLE:       state_d = IDLE;
        RST_LOW:    if (rise) state_d = PRES_WAIT;
        PRES_WAIT:  if (cnt_q == PWT_M1) state_d = PRES_DRIVE;
        PRES_DRIVE: if (cnt_q == PRES_M1) state_d = BYTE_START;
        BYTE_START: state_d = SLOT_WAIT;
        SLOT_WAIT: begin
          if (fall && !ow_oe_q) begin
            if (mode_q == MODE_RX) state_d = RX_SAMPLE;
            else if (sh_q[0])      state_d = SLOT_END;
            else                   state_d = TX_HOLD;
          end
        end
        RX_SAMPLE:  if (cnt_q == SMP_M1) state_d = SLOT_END;
        TX_HOLD:    if (cnt_q == HOLD_M1) state_d = SLOT_END;
        SLOT_END:   if (lvl) state_d = (bit_cnt_q == 3'd7) ? BYTE_START : SLOT_WAIT;
        default:    state_d = IDLE;
      endcase
    end
  end

  // ---------------- datapath next values ----------------
  always_comb begin
    cnt_d     = (state_d != state_q) ? '0 : ((&cnt_q) ? cnt_q : cnt_q + CW'(1));
    low_cnt_d = lvl ? '0 : ((low_cnt_q == LOW_TH) ? low_cnt_q : low_cnt_q + CW'(1));
    mode_d    = mode_q;
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    rx_dat_d  = rx_dat_q;
    rx_vld_d  = 1'b0;
    bus_rst_d = rst_hit;
    if (rst_hit) begin
      // Abandon any partial byte in either direction
      mode_d    = MODE_RX;
      sh_d      = '0;
      bit_cnt_d = '0;
    end else begin
      unique case (state_q)
        PRES_DRIVE: if (state_d == BYTE_START) bit_cnt_d = '0;
        BYTE_START: begin
          if (tx_vld) begin
            sh_d   = tx_dat;
            mode_d = MODE_TX;
          end else begin
            mode_d = MODE_RX;
          end
        end
        RX_SAMPLE: if (state_d == SLOT_END) sh_d = {lvl, sh_q[7:1]};
        SLOT_END: begin
          if (lvl) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (mode_q == MODE_TX) sh_d = {1'b0, sh_q[7:1]};
            if (bit_cnt_q == 3'd7 && mode_q == MODE_RX) begin
              rx_dat_d = sh_q;
              rx_vld_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_10 or negedge arst_n) begin
    if (!arst_n) begin
      mode_q    <= MODE_RX;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      low_cnt_q <= '0;
      rx_dat_q  <= '0;
      rx_vld_q  <= 1'b0;
      bus_rst_q <= 1'b0;
      ow_oe_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
      low_cnt_q <= low_cnt_d;
      rx_dat_q  <= rx_dat_d;
      rx_vld_q  <= rx_vld_d;
      bus_rst_q <= bus_rst_d;
      ow_oe_q   <= ow_oe_d;
      busy_q    <= busy_d;
    end
  end

  // ---------------- output logic ----------------
  // Bus drive and busy are registered from the next state so they are glitch-free
  always_comb begin
    ow_oe_d = (state_d == PRES_DRIVE) || (state_d == TX_HOLD);
    busy_d  = (state_d == RST_LOW) || (state_d == PRES_WAIT) || (state_d == PRES_DRIVE) ||
              (state_d == RX_SAMPLE) || (state_d == TX_HOLD) || (state_d == SLOT_END) ||
              ((state_d == SLOT_WAIT) && (bit_cnt_d != 3'd0));
    tx_rdy  = (state_q == BYTE_START) && tx_vld && !rst_hit;
  end

  assign ow_oe   = ow_oe_q;
  assign rx_dat  = rx_dat_q;
  assign rx_vld  = rx_vld_q;
  assign bus_rst = bus_rst_q;
  assign busy    = busy_q;

endmodule
